// File: rtl/led_color_fader.sv
// LED colour output register with a linear per-channel fade engine.
// Avalon-MM slave with zero read latency; out_port drives the LED driver.
module led_color_fader #(
  parameter int CH_W   = 8,
  parameter int NUM_CH = 3,
  parameter int PRE_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [1:0]               address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [NUM_CH*CH_W-1:0]   out_port,
  output logic                     busy
);

  localparam int W = NUM_CH * CH_W;

  generate
    if (W > 32) begin : g_bad_width
      $error("led_color_fader: NUM_CH*CH_W must not exceed 32");
    end
    if (PRE_W > 32) begin : g_bad_pre
      $error("led_color_fader: PRE_W must not exceed 32");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_FADING} state_t;

  state_t           r_state;
  logic [W-1:0]     r_cur;
  logic [W-1:0]     r_tgt;
  logic [PRE_W-1:0] r_pre;
  logic [PRE_W-1:0] r_cnt;
  logic             r_fade_en;

  logic             w_wr;
  logic             w_tick;
  logic [W-1:0]     w_wdata;
  logic [W-1:0]     w_step;
  logic [PRE_W-1:0] w_cnt_next;
  logic             w_unused;

  assign w_wr       = chipselect & ~write_n;
  assign w_wdata    = writedata[W-1:0];
  assign w_unused   = ^writedata;
  // A PRESCALE shrunk below the running count ticks at once rather than wrapping.
  assign w_tick     = (r_state == S_FADING) && (r_cnt >= r_pre);
  assign w_cnt_next = w_tick ? '0 : r_cnt + 1'b1;

  always_comb begin
    w_step = r_cur;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_cur[c*CH_W +: CH_W] < r_tgt[c*CH_W +: CH_W])
        w_step[c*CH_W +: CH_W] = r_cur[c*CH_W +: CH_W] + 1'b1;
      else if (r_cur[c*CH_W +: CH_W] > r_tgt[c*CH_W +: CH_W])
        w_step[c*CH_W +: CH_W] = r_cur[c*CH_W +: CH_W] - 1'b1;
    end
  end

  // A bus write always wins over a fade tick in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cur     <= '0;
      r_tgt     <= '0;
      r_pre     <= '0;
      r_cnt     <= '0;
      r_fade_en <= 1'b0;
    end else if (w_wr) begin
      case (address)
        2'd0: begin
          r_tgt <= w_wdata;
          r_cnt <= '0;
          if (r_fade_en) begin
            r_state <= (w_wdata != r_cur) ? S_FADING : S_IDLE;
          end else begin
            r_cur   <= w_wdata;
            r_state <= S_IDLE;
          end
        end
        2'd1: begin
          r_cur   <= w_wdata;
          r_tgt   <= w_wdata;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
        2'd2: begin
          r_pre <= writedata[PRE_W-1:0];
          if (r_state == S_FADING) r_cnt <= w_cnt_next;
        end
        default: begin
          r_fade_en <= writedata[0];
          if (r_state == S_FADING) begin
            if (!writedata[0]) begin
              r_cur   <= r_tgt;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else begin
              r_cnt <= w_cnt_next;
            end
          end
        end
      endcase
    end else if (r_state == S_FADING) begin
      if (w_tick) begin
        r_cur <= w_step;
        r_cnt <= '0;
        if (w_step == r_tgt) r_state <= S_IDLE;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out_port = r_cur;
  assign busy     = (r_state == S_FADING);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[W-1:0]     = r_tgt;
      2'd1:    readdata[W-1:0]     = r_cur;
      2'd2:    readdata[PRE_W-1:0] = r_pre;
      default: readdata[1:0]       = {busy, r_fade_en};
    endcase
  end

endmodule

// File: tb/tb_led_color_fader.sv
// Self-checking bench for led_color_fader: vector table, hand-written fade
// sequences and randomized bus traffic against a channel-level reference model.
module tb_led_color_fader;

  localparam int CH_W   = 8;
  localparam int NUM_CH = 3;
  localparam int PRE_W  = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [23:0] out_port;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  led_color_fader #(.CH_W(CH_W), .NUM_CH(NUM_CH), .PRE_W(PRE_W)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: colour as per-channel integers, fade as an integer countdown.
  int m_cur[NUM_CH];
  int m_tgt[NUM_CH];
  int m_pre;
  int m_cnt;
  bit m_en;
  bit m_fading;

  function automatic logic [31:0] pack_cur();
    logic [31:0] v = 0;
    for (int c = 0; c < NUM_CH; c++) v = v | (32'(m_cur[c]) << (c * CH_W));
    return v;
  endfunction

  function automatic logic [31:0] pack_tgt();
    logic [31:0] v = 0;
    for (int c = 0; c < NUM_CH; c++) v = v | (32'(m_tgt[c]) << (c * CH_W));
    return v;
  endfunction

  function automatic bool_differs();
    for (int c = 0; c < NUM_CH; c++) if (m_cur[c] != m_tgt[c]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin m_cur[c] = 0; m_tgt[c] = 0; end
    m_pre = 0; m_cnt = 0; m_en = 0; m_fading = 0;
  endfunction

  function automatic void model_clock(input bit wr, input logic [1:0] a, input logic [31:0] d);
    bit tick = m_fading && (m_cnt >= m_pre);
    if (wr) begin
      case (a)
        2'd0: begin
          for (int c = 0; c < NUM_CH; c++) m_tgt[c] = int'((d >> (c * CH_W)) & 32'hFF);
          m_cnt = 0;
          if (!m_en) begin
            for (int c = 0; c < NUM_CH; c++) m_cur[c] = m_tgt[c];
            m_fading = 0;
          end else m_fading = bool_differs();
        end
        2'd1: begin
          for (int c = 0; c < NUM_CH; c++) begin
            m_cur[c] = int'((d >> (c * CH_W)) & 32'hFF);
            m_tgt[c] = m_cur[c];
          end
          m_cnt = 0; m_fading = 0;
        end
        2'd2: begin
          m_pre = int'(d & 32'hFFFF);
          if (m_fading) m_cnt = tick ? 0 : m_cnt + 1;
        end
        default: begin
          m_en = d[0];
          if (m_fading && !d[0]) begin
            for (int c = 0; c < NUM_CH; c++) m_cur[c] = m_tgt[c];
            m_cnt = 0; m_fading = 0;
          end else if (m_fading) m_cnt = tick ? 0 : m_cnt + 1;
        end
      endcase
    end else if (m_fading) begin
      if (tick) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (m_cur[c] < m_tgt[c]) m_cur[c]++;
          else if (m_cur[c] > m_tgt[c]) m_cur[c]--;
        end
        m_cnt = 0;
        m_fading = bool_differs();
      end else m_cnt++;
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return pack_tgt();
      2'd1:    return pack_cur();
      2'd2:    return 32'(m_pre);
      default: return {30'd0, m_fading, m_en};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: optional write, model update, then compare outputs after the edge.
  task automatic step(input bit wr, input logic [1:0] a, input logic [31:0] d);
    chipselect = wr; write_n = ~wr; address = a; writedata = d;
    @(posedge clk);
    model_clock(wr, a, d);
    #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = $urandom;
    check("out_port", {8'd0, out_port}, pack_cur());
    check("busy", {31'd0, busy}, {31'd0, m_fading});
  endtask

  task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{2'd0, 32'h00FF8040, 32'h00FF8040, 32'h00FF8040};
    vecs[1] = '{2'd1, 32'hAA123456, 32'h00123456, 32'h00123456};
    vecs[2] = '{2'd2, 32'hFFFF0005, 32'h00123456, 32'h00000005};
    vecs[3] = '{2'd0, 32'h000000FF, 32'h000000FF, 32'h000000FF};
    vecs[4] = '{2'd3, 32'hFFFFFFFE, 32'h000000FF, 32'h00000000};
    vecs[5] = '{2'd1, 32'h00000000, 32'h00000000, 32'h00000000};

    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'd0;
    model_reset();
    #22 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < 4; a++) read_check("reset_read", 2'(a), 32'd0);
    check("reset_out", {8'd0, out_port}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Write-through behaviour with fading disabled.
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].addr, vecs[i].data);
      check("vec_out", {8'd0, out_port}, vecs[i].exp_out);
      check("vec_busy", {31'd0, busy}, 32'd0);
      read_check("vec_rd", vecs[i].addr, vecs[i].exp_rd);
      read_check("vec_cur_rd", 2'd1, vecs[i].exp_out);
    end

    // Up-fade, PRESCALE=3.
    step(1'b1, 2'd3, 32'd1);
    step(1'b1, 2'd2, 32'd3);
    step(1'b1, 2'd1, 32'd0);
    step(1'b1, 2'd0, 32'h000302);
    check("up_busy_rise", {31'd0, busy}, 32'd1);
    for (int e = 1; e <= 12; e++) begin
      step(1'b0, 2'd0, 32'd0);
      if (e == 3)  check("up_e3", {8'd0, out_port}, 32'h000000);
      if (e == 4)  check("up_e4", {8'd0, out_port}, 32'h000101);
      if (e == 8)  check("up_e8", {8'd0, out_port}, 32'h000202);
      if (e == 11) check("up_e11_busy", {31'd0, busy}, 32'd1);
      if (e == 12) begin
        check("up_e12", {8'd0, out_port}, 32'h000302);
        check("up_e12_busy", {31'd0, busy}, 32'd0);
      end
    end

    // Down-fade, PRESCALE=0, no underflow.
    step(1'b1, 2'd2, 32'd0);
    step(1'b1, 2'd1, 32'h050505);
    step(1'b1, 2'd0, 32'h020503);
    step(1'b0, 2'd0, 32'd0);
    check("down_e1", {8'd0, out_port}, 32'h040504);
    step(1'b0, 2'd0, 32'd0);
    check("down_e2", {8'd0, out_port}, 32'h030503);
    check("down_e2_busy", {31'd0, busy}, 32'd1);
    step(1'b0, 2'd0, 32'd0);
    check("down_e3", {8'd0, out_port}, 32'h020503);
    check("down_e3_busy", {31'd0, busy}, 32'd0);
    idle(2);
    check("down_hold", {8'd0, out_port}, 32'h020503);

    // Retarget on a tick cycle, then disable fading mid-fade.
    step(1'b1, 2'd2, 32'd3);
    step(1'b1, 2'd1, 32'd0);
    step(1'b1, 2'd0, 32'h000010);
    idle(3);
    step(1'b1, 2'd0, 32'h000020);
    check("retgt_nostep", {8'd0, out_port}, 32'h000000);
    idle(3);
    check("retgt_e3", {8'd0, out_port}, 32'h000000);
    idle(1);
    check("retgt_e4", {8'd0, out_port}, 32'h000001);
    step(1'b1, 2'd3, 32'd0);
    check("snap_out", {8'd0, out_port}, 32'h000020);
    check("snap_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset between clock edges mid-fade.
    step(1'b1, 2'd3, 32'd1);
    step(1'b1, 2'd2, 32'd1);
    step(1'b1, 2'd0, 32'h808080);
    idle(5);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out", {8'd0, out_port}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    model_reset();
    read_check("arst_ctrl", 2'd3, 32'd0);
    #1 reset_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      bit          wr;
      wr = ($urandom_range(0, 7) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = $urandom;
      if (a == 2'd2) d = 32'($urandom_range(0, 3));
      if (a == 2'd3 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      step(wr, a, d);
      a = 2'($urandom_range(0, 3));
      read_check("rand_rd", a, model_read(a));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
